prog_boot_ctrl: RTL and testbench

- Boot/run sequencer for the 8-bit accumulator core.
- Receives a framed program image over a byte-wide valid/ready stream and writes it into the core's instruction memory through the memory write port (we/addr/data).
- Verifies an 8-bit checksum, then releases the core to run and counts clock cycles until the core reports HALT.
- Sits between the chip I/O pins and the core. It is the only writer of instruction memory and the only driver of the core's run enable.

---
 rtl/prog_boot_ctrl.sv | 170 +++++++++++++++++
 tb/tb_prog_boot_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_boot_ctrl.sv
// Boot/run sequencer: loads a framed, checksummed program image into instruction memory,
// then releases the accumulator core and counts its run cycles until HALT.
module prog_boot_ctrl #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned MEM_DEPTH = 25,
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [7:0]        mem_wdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  input  logic              core_halt_i,
  output logic              core_run_o,
  output logic              busy_o,
  output logic              load_ok_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [CNT_W-1:0]  run_cycles_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StMagic = 3'd1;
  localparam logic [2:0] StLen   = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StChk   = 3'd4;
  localparam logic [2:0] StRun   = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;
  localparam logic [2:0] StErr   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              core_run_q, core_run_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;

  logic       xfer;
  logic       start_ok;
  logic [7:0] chk_sum;

  assign in_ready_o = (state_q == StMagic) || (state_q == StLen) ||
                      (state_q == StData)  || (state_q == StChk);
  assign xfer       = in_valid_i && in_ready_o;
  assign start_ok   = start_i && !in_ready_o;
  assign chk_sum    = sum_q + in_data_i;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_code_d  = err_code_q;
    run_cnt_d   = run_cnt_q;

    if (start_ok) begin
      state_d    = StMagic;
      err_code_d = 2'b00;
    end else begin
      case (state_q)
        StMagic: begin
          if (xfer) begin
            if (in_data_i == MAGIC) begin
              state_d = StLen;
            end else begin
              state_d    = StErr;
              err_code_d = 2'b01;
            end
          end
        end
        StLen: begin
          if (xfer) begin
            len_d = in_data_i;
            idx_d = '0;
            sum_d = '0;
            if (in_data_i == 8'd0 || in_data_i > 8'(MEM_DEPTH)) begin
              state_d    = StErr;
              err_code_d = 2'b10;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          if (xfer) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q;
            mem_wdata_d = in_data_i;
            sum_d       = sum_q + in_data_i;
            idx_d       = idx_q + 1'b1;
            if (8'(idx_q) == len_q - 8'd1) begin
              state_d = StChk;
            end
          end
        end
        StChk: begin
          if (xfer) begin
            if (chk_sum == 8'd0) begin
              state_d   = StRun;
              run_cnt_d = '0;
            end else begin
              state_d    = StErr;
              err_code_d = 2'b11;
            end
          end
        end
        StRun: begin
          if (core_halt_i) begin
            state_d = StDone;
          end else if (core_run_q && run_cnt_q != {CNT_W{1'b1}}) begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Run enable lags RUN entry by one cycle and stays up through DONE.
    core_run_d = ((state_d == StRun) && (state_q == StRun)) || (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_run_q  <= 1'b0;
      err_code_q  <= 2'b00;
      run_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_run_q  <= core_run_d;
      err_code_q  <= err_code_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign core_run_o   = core_run_q;
  assign busy_o       = in_ready_o || (state_q == StRun);
  assign load_ok_o    = (state_q == StRun) || (state_q == StDone);
  assign err_o        = (state_q == StErr);
  assign err_code_o   = err_code_q;
  assign run_cycles_o = run_cnt_q;

endmodule

// File: tb/tb_prog_boot_ctrl.sv
// Directed bench for prog_boot_ctrl: a table of frames with hand-computed outcomes,
// followed by reset and start-pulse corner sequences.
module tb_prog_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  in_data_i = 8'h00;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  mem_wdata_o;
  logic [4:0]  mem_addr_o;
  logic        mem_we_o;
  logic        core_halt_i = 1'b0;
  logic        core_run_o;
  logic        busy_o;
  logic        load_ok_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [15:0] run_cycles_o;

  prog_boot_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .core_halt_i  (core_halt_i),
    .core_run_o   (core_run_o),
    .busy_o       (busy_o),
    .load_ok_o    (load_ok_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o),
    .run_cycles_o (run_cycles_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b [32];
    int         n;
    int         gap;
    logic [1:0] ecode;
    int         nwr;
    int         ndbl;
    logic       run;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int nvec = 0;
  int nfail = 0;

  // Write log captured mid-cycle; ndbl counts back-to-back write cycles.
  logic [7:0] log_data [256];
  logic [4:0] log_addr [256];
  int         wcnt = 0;
  int         dbl = 0;
  logic       prev_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we_o) begin
      log_data[wcnt % 256] <= mem_wdata_o;
      log_addr[wcnt % 256] <= mem_addr_o;
      wcnt <= wcnt + 1;
      if (prev_we) dbl <= dbl + 1;
    end
    prev_we <= mem_we_o;
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input int k, input int n, input logic [63:0] bytes, input int gap,
                     input logic [1:0] ecode, input int nwr, input int ndbl, input logic run);
    for (int i = 0; i < 32; i++) vecs[k].b[i] = 8'h00;
    for (int i = 0; i < n; i++) vecs[k].b[i] = bytes[8*(n-1-i) +: 8];
    vecs[k].n     = n;
    vecs[k].gap   = gap;
    vecs[k].ecode = ecode;
    vecs[k].nwr   = nwr;
    vecs[k].ndbl  = ndbl;
    vecs[k].run   = run;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i  = b;
    while (!in_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready_o), 0);
    chk({tag, "_mem_we"}, int'(mem_we_o), 0);
    chk({tag, "_core_run"}, int'(core_run_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_load_ok"}, int'(load_ok_o), 0);
    chk({tag, "_err"}, int'(err_o), 0);
    chk({tag, "_err_code"}, int'(err_code_o), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr_o), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata_o), 0);
    chk({tag, "_run_cycles"}, int'(run_cycles_o), 0);
  endtask

  // Wait for core_run to rise, hold halt low for 7 run cycles, then halt.
  task automatic halt_after_7();
    @(posedge clk);
    #1;
    chk("run_rises", int'(core_run_o), 1);
    chk("run_busy", int'(busy_o), 1);
    chk("run_load_ok", int'(load_ok_o), 1);
    repeat (7) @(posedge clk);
    #1;
    core_halt_i = 1'b1;
    @(posedge clk);
    #1;
    core_halt_i = 1'b0;
    @(negedge clk);
    chk("done_run_cycles", int'(run_cycles_o), 7);
    chk("done_load_ok", int'(load_ok_o), 1);
    chk("done_core_run", int'(core_run_o), 1);
    chk("done_busy", int'(busy_o), 0);
  endtask

  task automatic run_vec(input int k);
    int wbase;
    int dbase;
    pulse_start();
    chk($sformatf("v%0d_start_ready", k), int'(in_ready_o), 1);
    chk($sformatf("v%0d_start_run", k), int'(core_run_o), 0);
    chk($sformatf("v%0d_start_err", k), int'(err_o), 0);
    wbase = wcnt;
    dbase = dbl;
    for (int i = 0; i < vecs[k].n; i++) begin
      if (i > 0) repeat (vecs[k].gap) @(negedge clk);
      send_byte(vecs[k].b[i]);
    end
    chk($sformatf("v%0d_err", k), int'(err_o), vecs[k].run ? 0 : 1);
    chk($sformatf("v%0d_err_code", k), int'(err_code_o), int'(vecs[k].ecode));
    chk($sformatf("v%0d_ready", k), int'(in_ready_o), 0);
    chk($sformatf("v%0d_core_run", k), int'(core_run_o), 0);
    if (vecs[k].run) halt_after_7();
    else begin
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_err_core_run", k), int'(core_run_o), 0);
    end
    #1;
    chk($sformatf("v%0d_writes", k), wcnt - wbase, vecs[k].nwr);
    chk($sformatf("v%0d_b2b", k), dbl - dbase, vecs[k].ndbl);
    for (int i = 0; i < vecs[k].nwr; i++) begin
      chk($sformatf("v%0d_addr%0d", k, i), int'(log_addr[(wbase + i) % 256]), i);
      chk($sformatf("v%0d_data%0d", k, i), int'(log_data[(wbase + i) % 256]),
          int'(vecs[k].b[2 + i]));
    end
  endtask

  initial begin
    put(0, 6, 64'hA5_03_01_05_0A_F0, 0, 2'b00, 3, 2, 1'b1);
    put(1, 1, 64'h5A, 0, 2'b01, 0, 0, 1'b0);
    put(2, 2, 64'hA5_00, 0, 2'b10, 0, 0, 1'b0);
    put(3, 2, 64'hA5_1A, 0, 2'b10, 0, 0, 1'b0);
    put(4, 5, 64'hA5_02_01_02_00, 0, 2'b11, 2, 1, 1'b0);
    put(5, 6, 64'hA5_03_01_05_0A_F0, 0, 2'b00, 3, 2, 1'b1);
    put(6, 6, 64'hA5_03_01_05_0A_F0, 2, 2'b00, 3, 0, 1'b1);
    put(7, 4, 64'hA5_01_7F_81, 0, 2'b00, 1, 0, 1'b1);
    // Maximum length: bytes 1..25 sum to 0x145, checksum 0xBB.
    put(8, 2, 64'hA5_19, 0, 2'b00, 25, 24, 1'b1);
    for (int i = 0; i < 25; i++) vecs[8].b[2 + i] = 8'(i + 1);
    vecs[8].b[27] = 8'hBB;
    vecs[8].n = 28;

    #3;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", int'(in_ready_o), 0);

    for (int k = 0; k < NVEC; k++) run_vec(k);

    // From DONE: start drops core_run, keeps run_cycles, then mid-DATA start is ignored.
    pulse_start();
    chk("done_start_run", int'(core_run_o), 0);
    chk("done_start_ready", int'(in_ready_o), 1);
    chk("done_start_keep_cycles", int'(run_cycles_o), 7);
    chk("done_start_load_ok", int'(load_ok_o), 0);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h01);
    pulse_start();
    chk("mid_data_start_ready", int'(in_ready_o), 1);
    send_byte(8'h05);
    send_byte(8'h0A);
    send_byte(8'hF0);
    chk("mid_data_start_err", int'(err_o), 0);
    @(posedge clk);
    #1;
    chk("mid_data_start_run", int'(core_run_o), 1);
    chk("rerun_cycles_cleared", int'(run_cycles_o), 0);

    // From RUN: start restarts the load; reset mid-DATA clears everything at once.
    pulse_start();
    chk("run_start_core_run", int'(core_run_o), 0);
    chk("run_start_ready", int'(in_ready_o), 1);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h01);
    @(negedge clk);
    chk("pre_reset_we_data", int'(mem_wdata_o), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_data_reset");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid_i = 1'b1;
    in_data_i = 8'hA5;
    repeat (3) @(negedge clk);
    chk("post_reset_idle_ready", int'(in_ready_o), 0);
    chk("post_reset_idle_busy", int'(busy_o), 0);
    in_valid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
